// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Arbiter and sequencer for a shared 4:1 WIDTH-bit data mux. Four requesters
//   compete for one registered output channel. The owner may send bursts of up
//   to MAXBURST beats before the grant is rotated.
//
// Optional build macro:
//   MUXARB_FIXED_PRIO_EN  - when defined, IDLE arbitration uses fixed priority
//                           (requester 0 highest). The round-robin pointer is
//                           not used. The default build uses round-robin.
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   Req[3:0]   Req[i] high: requester i offers a beat on Data<i>
//   Data0..3   requester data
//   Ack[3:0]   combinational; Ack[i] high: the Data<i> beat is consumed this cycle
//   Grant[3:0] registered one-hot owner, or zero when no owner
//   Select     registered owner index, drives the mux select
//   Out        registered output data
//   OutValid   registered; Out holds a valid beat
//   OutReady   downstream accepts Out this cycle
module mux4_rr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       Req,
    input  logic [WIDTH-1:0] Data0,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    input  logic [WIDTH-1:0] Data3,
    output logic [3:0]       Ack,
    output logic [3:0]       Grant,
    output logic [1:0]       Select,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid,
    input  logic             OutReady
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       r_select;
    logic [1:0]       w_select_nxt;
    logic [3:0]       r_beatcnt;
    logic [3:0]       w_beatcnt_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic             r_outvalid;
    logic             w_outvalid_nxt;

    logic             w_free;
    logic             w_ack_own;
    logic             w_release;
    logic [3:0]       w_cnt_inc;
    logic [1:0]       w_winner;
    logic [WIDTH-1:0] w_data;

    // The output register can take a new beat when it is empty or being drained.
    assign w_free    = !r_outvalid || OutReady;
    assign w_ack_own = (r_state == ST_GRANT) && Req[r_select] && w_free;
    assign w_cnt_inc = r_beatcnt + 4'd1;

    // Release when the owner withdraws (no Ack that cycle) or on its last
    // permitted beat; the final beat and the release happen together.
    assign w_release = (r_state == ST_GRANT) &&
                       (!Req[r_select] || (w_ack_own && (w_cnt_inc == 4'(MAXBURST))));

    always_comb begin
        Ack = 4'b0000;
        if (w_ack_own) begin
            Ack = 4'b0001 << r_select;
        end
    end

    always_comb begin
        case (r_select)
            2'd0:    w_data = Data0;
            2'd1:    w_data = Data1;
            2'd2:    w_data = Data2;
            default: w_data = Data3;
        endcase
    end

`ifdef MUXARB_FIXED_PRIO_EN
    always_comb begin
        if (Req[0])      w_winner = 2'd0;
        else if (Req[1]) w_winner = 2'd1;
        else if (Req[2]) w_winner = 2'd2;
        else             w_winner = 2'd3;
    end
`else
    logic [1:0] r_last;

    // Scan Last+1, Last+2, ... so the previous owner is considered last.
    always_comb begin : rr_scan
        logic [1:0] v_idx;
        logic       v_found;
        w_winner = r_last + 2'd1;
        v_found  = 1'b0;
        v_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!v_found && Req[v_idx]) begin
                w_winner = v_idx;
                v_found  = 1'b1;
            end
        end
    end

    // Last starts at 3 so requester 0 wins the first arbitration.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last <= 2'd3;
        end else if (w_release) begin
            r_last <= r_select;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_select_nxt   = r_select;
        w_beatcnt_nxt  = r_beatcnt;
        w_out_nxt      = r_out;
        w_outvalid_nxt = r_outvalid;

        case (r_state)
            ST_IDLE: begin
                if (Req != 4'b0000) begin
                    w_grant_nxt   = 4'b0001 << w_winner;
                    w_select_nxt  = w_winner;
                    w_beatcnt_nxt = 4'd0;
                    w_state_nxt   = ST_GRANT;
                end else begin
                    w_grant_nxt = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_grant_nxt   = 4'b0000;
                    w_beatcnt_nxt = 4'd0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_ack_own) begin
                    w_beatcnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase

        // Output stage: load on Ack, otherwise drain when downstream accepts.
        if (w_ack_own) begin
            w_out_nxt      = w_data;
            w_outvalid_nxt = 1'b1;
        end else if (OutReady) begin
            w_outvalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_select   <= 2'd0;
            r_beatcnt  <= 4'd0;
            r_out      <= '0;
            r_outvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_select   <= w_select_nxt;
            r_beatcnt  <= w_beatcnt_nxt;
            r_out      <= w_out_nxt;
            r_outvalid <= w_outvalid_nxt;
        end
    end

    assign Grant    = r_grant;
    assign Select   = r_select;
    assign Out      = r_out;
    assign OutValid = r_outvalid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed steps in one initial block, output
// beats checked against a queue of expected data filled as stimulus is driven.
module tb_mux4_rr_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAXBURST = 4;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic [3:0]       Req;
    logic [WIDTH-1:0] Data0, Data1, Data2, Data3;
    logic [3:0]       Ack;
    logic [3:0]       Grant;
    logic [1:0]       Select;
    logic [WIDTH-1:0] Out;
    logic             OutValid;
    logic             OutReady;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 Clk = ~Clk;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .Data0    (Data0),
        .Data1    (Data1),
        .Data2    (Data2),
        .Data3    (Data3),
        .Ack      (Ack),
        .Grant    (Grant),
        .Select   (Select),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] dat(input int i);
        case (i)
            0:       return 32'hF0F0F0F0;
            1:       return 32'hF8F8F8F8;
            2:       return 32'hFBFBFBFB;
            default: return 32'hFEFEFEFE;
        endcase
    endfunction

    // Owner of the k-th grant when all four requesters are asking.
    function automatic int own_all(input int k);
`ifdef MUXARB_FIXED_PRIO_EN
        return 0;
`else
        return k % 4;
`endif
    endfunction

    // Every accepted output beat must be the next expected one.
    always @(negedge Clk) begin
        if (OutValid === 1'b1 && OutReady === 1'b1) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("beat_data", Out, exp_q.pop_front());
            end
        end
    end

    initial begin
        int w4;
        Data0    = dat(0);
        Data1    = dat(1);
        Data2    = dat(2);
        Data3    = dat(3);
        Reset_n  = 1'b0;
        Req      = 4'b1111;
        OutReady = 1'b1;

        // Reset held with all requests pending.
        tick();
        tick();
        check("rst_grant", Grant, 4'b0000);
        check("rst_outvalid", OutValid, 1'b0);
        check("rst_out", Out, 32'h0);
        check("rst_ack", Ack, 4'b0000);
        check("rst_select", Select, 2'd0);

        // Full contention, 5 grants of MAXBURST beats each with a bubble between.
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < MAXBURST; b++) exp_q.push_back(dat(own_all(k)));
        end
        Reset_n = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if ((c - 1) % 5 == 4) begin
                check("rr_bubble_grant", Grant, 4'b0000);
            end else begin
                check("rr_grant", Grant, 32'(4'b0001 << own_all((c - 1) / 5)));
                check("rr_select", Select, 32'(own_all((c - 1) / 5)));
            end
        end
        Req = 4'b0000;
        tick();
        tick();
        check("rr_drain_valid", OutValid, 1'b0);
        check("rr_drain_queue", 32'(exp_q.size()), 32'd0);

        // Single requester with backpressure pattern 1,0,0,1.
        Req = 4'b0100;
        for (int b = 0; b < MAXBURST; b++) exp_q.push_back(dat(2));
        tick();
        check("bp_grant", Grant, 4'b0100);
        check("bp_select", Select, 2'd2);
        for (int c = 1; c <= 8; c++) begin
            OutReady = (c % 4 == 1) || (c % 4 == 0);
            #1;
            check("bp_ack", Ack, OutReady ? 4'b0100 : 4'b0000);
            if (!OutReady) begin
                check("bp_hold_out", Out, dat(2));
                check("bp_hold_valid", OutValid, 1'b1);
            end
            tick();
        end
        Req      = 4'b0000;
        OutReady = 1'b1;
        check("bp_release", Grant, 4'b0000);
        tick();
        tick();
        check("bp_drain_valid", OutValid, 1'b0);
        check("bp_drain_queue", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-burst after two beats.
`ifdef MUXARB_FIXED_PRIO_EN
        w4 = 0;
`else
        w4 = 3;
`endif
        Req = 4'b1111;
        exp_q.push_back(dat(w4));
        tick();
        check("mid_grant", Grant, 32'(4'b0001 << w4));
        tick();
        tick();
        Reset_n = 1'b0;
        #1;
        check("mid_rst_grant", Grant, 4'b0000);
        check("mid_rst_valid", OutValid, 1'b0);
        check("mid_rst_out", Out, 32'h0);
        check("mid_rst_ack", Ack, 4'b0000);
        tick();
        Reset_n = 1'b1;
        tick();
        check("restart_grant", Grant, 4'b0001);
        check("restart_select", Select, 2'd0);

        // Owner 0 withdraws at once, then owner 1 withdraws after 2 beats.
        Req = 4'b1010;
        #1;
        check("drop0_ack", Ack, 4'b0000);
        tick();
        check("drop0_release", Grant, 4'b0000);
        exp_q.push_back(dat(1));
        exp_q.push_back(dat(1));
        tick();
        check("own1_grant", Grant, 4'b0010);
        check("own1_select", Select, 2'd1);
        tick();
        tick();
        Req = 4'b1000;
        #1;
        check("drop1_ack", Ack, 4'b0000);
        tick();
        check("drop1_release", Grant, 4'b0000);
        tick();
        check("own3_grant", Grant, 4'b1000);
        check("own3_select", Select, 2'd3);
        Req = 4'b0000;
        tick();
        tick();
        tick();
        check("end_grant", Grant, 4'b0000);
        check("end_valid", OutValid, 1'b0);
        check("end_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
